// File: rtl/edge_detector.sv
// Bit-parallel edge detector: compares the live input against a history
// register captured on the previous enabled clock and flags rising/falling edges.
module edge_detector #(
  parameter int unsigned    WID  = 1,
  parameter logic [WID-1:0] INIT = '0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic [WID-1:0] i,
  output logic [WID-1:0] pe,
  output logic [WID-1:0] ne,
  output logic [WID-1:0] ee
);

  logic [WID-1:0] q;

  // History register; reset reloads INIT so the comparison restarts from it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= INIT;
    end else if (ce) begin
      q <= i;
    end
  end

  // Zero-latency edge flags, held low for the whole of reset.
  always_comb begin
    pe = '0;
    ne = '0;
    ee = '0;
    if (!rst) begin
      pe = i & ~q;
      ne = ~i & q;
      ee = i ^ q;
    end
  end

endmodule

// File: tb/tb_edge_detector.sv
// Self-checking bench for edge_detector: vector table, hand-written corner
// sequences and randomized stimulus against a per-bit behavioural model.
module tb_edge_detector;

  localparam int unsigned WID = 4;
  localparam logic [WID-1:0] INIT = 4'b0000;

  logic           clk;
  logic           rst;
  logic           ce;
  logic [WID-1:0] i;
  logic [WID-1:0] pe;
  logic [WID-1:0] ne;
  logic [WID-1:0] ee;

  int checks;
  int errors;

  // Model state: the value of i seen at the last enabled clock (or INIT).
  logic [WID-1:0] last_seen;

  edge_detector #(.WID(WID), .INIT(INIT)) dut (
    .clk(clk),
    .rst(rst),
    .ce (ce),
    .i  (i),
    .pe (pe),
    .ne (ne),
    .ee (ee)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           ce;
    logic [WID-1:0] i;
    logic [WID-1:0] pe;
    logic [WID-1:0] ne;
    logic [WID-1:0] ee;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [WID-1:0] got,
                       input logic [WID-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
    end
  endtask

  // Per-bit rule: rising = now high and previously low, and so on.
  task automatic check_model(input string name);
    logic [WID-1:0] xp;
    logic [WID-1:0] xn;
    logic [WID-1:0] xe;
    xp = '0;
    xn = '0;
    xe = '0;
    if (!rst) begin
      for (int b = 0; b < int'(WID); b++) begin
        if (i[b] == 1'b1 && last_seen[b] == 1'b0) xp[b] = 1'b1;
        if (i[b] == 1'b0 && last_seen[b] == 1'b1) xn[b] = 1'b1;
        if (i[b] != last_seen[b])                 xe[b] = 1'b1;
      end
    end
    check({name, ".pe"}, pe, xp);
    check({name, ".ne"}, ne, xn);
    check({name, ".ee"}, ee, xe);
    check({name, ".pe_and_ne"}, pe & ne, '0);
    check({name, ".ee_is_or"}, ee, pe | ne);
  endtask

  // One cycle: drive after the rising edge, sample at the falling edge.
  task automatic apply(input logic r, input logic c, input logic [WID-1:0] v);
    rst = r;
    ce  = c;
    i   = v;
    if (r) last_seen = INIT;
    @(negedge clk);
    check_model("rand");
    @(posedge clk);
    if (!r && c) last_seen = v;
    #1;
  endtask

  task automatic drive(input logic c, input logic [WID-1:0] v);
    ce = c;
    i  = v;
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    last_seen = INIT;

    tbl[0] = '{ce: 1'b1, i: 4'b0011, pe: 4'b0011, ne: 4'b0000, ee: 4'b0011};
    tbl[1] = '{ce: 1'b1, i: 4'b0011, pe: 4'b0000, ne: 4'b0000, ee: 4'b0000};
    tbl[2] = '{ce: 1'b1, i: 4'b0101, pe: 4'b0100, ne: 4'b0010, ee: 4'b0110};
    tbl[3] = '{ce: 1'b1, i: 4'b0011, pe: 4'b0010, ne: 4'b0100, ee: 4'b0110};
    tbl[4] = '{ce: 1'b0, i: 4'b1111, pe: 4'b1100, ne: 4'b0000, ee: 4'b1100};
    tbl[5] = '{ce: 1'b1, i: 4'b1111, pe: 4'b1100, ne: 4'b0000, ee: 4'b1100};
    tbl[6] = '{ce: 1'b1, i: 4'b0000, pe: 4'b0000, ne: 4'b1111, ee: 4'b1111};
    tbl[7] = '{ce: 1'b1, i: 4'b0000, pe: 4'b0000, ne: 4'b0000, ee: 4'b0000};

    // Reset held with i high: all outputs stay low across clock edges.
    rst = 1'b1;
    ce  = 1'b1;
    i   = 4'b1111;
    @(negedge clk);
    check("rst.pe", pe, 4'b0000);
    check("rst.ne", ne, 4'b0000);
    check("rst.ee", ee, 4'b0000);
    tick();
    @(negedge clk);
    check("rst_hold.ee", ee, 4'b0000);
    tick();

    // Release with i high: "already active" flagged for one cycle.
    rst = 1'b0;
    drive(1'b1, 4'b1111);
    check("rel.pe", pe, 4'b1111);
    check("rel.ne", ne, 4'b0000);
    check("rel.ee", ee, 4'b1111);
    tick();
    @(negedge clk);
    check("rel_next.pe", pe, 4'b0000);
    check("rel_next.ee", ee, 4'b0000);
    tick();

    // Return to zero so the table starts from a known history.
    drive(1'b1, 4'b0000);
    tick();
    drive(1'b1, 4'b0000);
    check("idle.ee", ee, 4'b0000);
    tick();

    for (int k = 0; k < 8; k++) begin
      drive(tbl[k].ce, tbl[k].i);
      check($sformatf("tbl%0d.pe", k), pe, tbl[k].pe);
      check($sformatf("tbl%0d.ne", k), ne, tbl[k].ne);
      check($sformatf("tbl%0d.ee", k), ee, tbl[k].ee);
      tick();
    end

    // Single-cycle pulse on bit 0.
    drive(1'b1, 4'b0001);
    check("pulse_n.pe", pe, 4'b0001);
    check("pulse_n.ee", ee, 4'b0001);
    tick();
    drive(1'b1, 4'b0000);
    check("pulse_n1.ne", ne, 4'b0001);
    check("pulse_n1.pe", pe, 4'b0000);
    check("pulse_n1.ee", ee, 4'b0001);
    tick();
    drive(1'b1, 4'b0000);
    check("pulse_n2.ee", ee, 4'b0000);
    tick();

    // Clock enable low: frozen history keeps reporting the level.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 4'b0001);
      check($sformatf("ce_off%0d.pe", k), pe, 4'b0001);
      tick();
    end
    drive(1'b1, 4'b0001);
    check("ce_on.pe", pe, 4'b0001);
    tick();
    drive(1'b1, 4'b0001);
    check("ce_on_next.pe", pe, 4'b0000);
    tick();

    // Asynchronous reset between clock edges while ne is active.
    ce = 1'b1;
    i  = 4'b0000;
    #2;
    check("async_pre.ne", ne, 4'b0001);
    rst = 1'b1;
    #1;
    check("async.ne", ne, 4'b0000);
    check("async.ee", ee, 4'b0000);
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("async_rel.pe", pe, 4'b0000);
    check("async_rel.ne", ne, 4'b0000);
    check("async_rel.ee", ee, 4'b0000);
    tick();

    // Randomized stimulus against the behavioural model.
    last_seen = INIT;
    for (int n = 0; n < 400; n++) begin
      logic r;
      r = ($urandom_range(0, 19) == 0);
      apply(r, 1'($urandom_range(0, 3) != 0), 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
